// File: rtl/dec_word_fmt.sv
// dec_word_fmt: double-dabble binary-to-decimal formatter producing a four-character ASCII word
module dec_word_fmt #(
    parameter int WIDTH = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [31:0]      word
);
    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [19:0]      bcd;
    logic [19:0]      adj;
    logic [4:0]       cnt;
    logic             b3, b2, b1;
    logic [31:0]      fmt;
    for (genvar i = 0; i < 5; i++) begin : g_adj
        assign adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end
    // Blanking ripples rightward and stops at the first nonzero digit; units never blank
    assign b3 = BLANK_LEADING && bcd[15:12] == 4'd0;
    assign b2 = b3 && bcd[11:8] == 4'd0;
    assign b1 = b2 && bcd[7:4] == 4'd0;
    assign fmt = bcd[19:16] != 4'd0 ? 32'h6F666C6F :
                 {b3 ? 8'h20 : {4'h3, bcd[15:12]},
                  b2 ? 8'h20 : {4'h3, bcd[11:8]},
                  b1 ? 8'h20 : {4'h3, bcd[7:4]},
                  {4'h3, bcd[3:0]}};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            word  <= 32'h20202020;
            bcd   <= '0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sh    <= value;
                    bcd   <= '0;
                    cnt   <= 5'(WIDTH);
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, sh} <= {adj, sh} << 1;
                    cnt       <= cnt - 5'd1;
                    if (cnt == 5'd1) state <= FORMAT;
                end
                FORMAT: begin
                    word  <= fmt;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
